// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin frame scheduler that serializes frames into an external sequence detector and reports match counts
module seq_det_sched #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             det_clr,
    output logic             det_seq,
    input  logic             det_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [CNT_W-1:0] res_count,
    output logic             busy
);
    localparam logic [1:0] IDLE = 2'd0, CLEAR = 2'd1, SHIFT = 2'd2, REPORT = 2'd3;
    logic [1:0]       state;
    logic             last_grant, pick1, idle;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_idx, count, count_nxt;
    // round-robin pick, ready gating (held low while reset is asserted) and saturating match count
    always_comb begin
        idle       = state == IDLE;
        pick1      = req1_valid && (!req0_valid || !last_grant);
        req0_ready = rst && idle && req0_valid && !pick1;
        req1_ready = rst && idle && pick1;
        busy       = !idle;
        count_nxt  = (det_out && count != {CNT_W{1'b1}}) ? count + CNT_W'(1) : count;
    end
    // frame FSM: grant, clear detector, shift MSB first, hold result until accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            shreg      <= '0;
            bit_idx    <= '0;
            count      <= '0;
            det_clr    <= 1'b0;
            det_seq    <= 1'b0;
            res_valid  <= 1'b0;
            res_id     <= 1'b0;
            res_count  <= '0;
        end else begin
            case (state)
                IDLE: if (req0_valid || req1_valid) begin
                    state   <= CLEAR;
                    res_id  <= pick1;
                    shreg   <= pick1 ? req1_data : req0_data;
                    det_clr <= 1'b1;
                end
                CLEAR: begin
                    state   <= SHIFT;
                    det_clr <= 1'b0;
                    det_seq <= shreg[WIDTH-1];
                    shreg   <= shreg << 1;
                    count   <= '0;
                    bit_idx <= '0;
                end
                SHIFT: begin
                    count <= count_nxt;
                    if (bit_idx == CNT_W'(WIDTH - 1)) begin
                        state     <= REPORT;
                        det_seq   <= 1'b0;
                        res_valid <= 1'b1;
                        res_count <= count_nxt;
                    end else begin
                        bit_idx <= bit_idx + CNT_W'(1);
                        det_seq <= shreg[WIDTH-1];
                        shreg   <= shreg << 1;
                    end
                end
                REPORT: if (res_ready) begin
                    state      <= IDLE;
                    res_valid  <= 1'b0;
                    last_grant <= res_id;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_det_sched.sv
// tb_seq_det_sched: table, corner-case and random checks of seq_det_sched driving a Mealy overlapping "101" detector
module tb_seq_det_sched;
    localparam int W = 8, CW = 4;
    logic          clk = 1'b0, rst = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b1;
    logic [W-1:0]  req0_data = '0, req1_data = '0;
    logic          req0_ready, req1_ready, det_clr, det_seq, det_out, res_valid, res_id, busy;
    logic [CW-1:0] res_count;
    logic [1:0]    ds;
    int            nvec = 0, nerr = 0, m_ph = 0, t;
    bit            m_busy = 1'b0, m_last = 1'b1, m_id = 1'b0, drop0, drop1;
    logic [W-1:0]  m_data = '0;
    logic [CW-1:0] m_cnt = '0;
    bit            a_id[$];
    logic [CW-1:0] a_cnt[$];
    typedef struct {
        bit v0, v1;
        logic [W-1:0] d0, d1;
        bit two, id_a;
        logic [CW-1:0] cnt_a;
        bit id_b;
        logic [CW-1:0] cnt_b;
    } vec_t;
    vec_t tv[7];

    always #5 clk = ~clk;

    seq_det_sched #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .det_clr(det_clr), .det_seq(det_seq), .det_out(det_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_count(res_count), .busy(busy)
    );

    // attached detector: 0 = nothing, 1 = saw "1", 2 = saw "10"; match is Mealy on det_seq
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ds <= 2'd0;
        else if (det_clr) ds <= 2'd0;
        else ds <= det_seq ? 2'd1 : (ds == 2'd1 ? 2'd2 : 2'd0);
    end
    assign det_out = det_seq && ds == 2'd2;

    function automatic logic [CW-1:0] ref_count(logic [W-1:0] d);
        int n = 0;
        for (int i = 0; i <= W - 3; i++) if (d[i+:3] == 3'b101) n++;
        return n > (2**CW - 1) ? CW'(2**CW - 1) : CW'(n);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic observe();
        bit e0, e1;
        if (!rst) begin
            chk("rst_out", 32'({req0_ready, req1_ready, det_clr, det_seq, res_valid, res_id, res_count, busy}), 32'd0);
            return;
        end
        chk("busy", 32'(busy), 32'(m_busy));
        if (!m_busy) begin
            e1 = req1_valid && (!req0_valid || !m_last);
            e0 = req0_valid && !e1;
            chk("ready0", 32'(req0_ready), 32'(e0));
            chk("ready1", 32'(req1_ready), 32'(e1));
            chk("idle_out", 32'({det_clr, det_seq, res_valid}), 32'd0);
            if (e0 || e1) begin
                m_busy = 1'b1;
                m_ph   = 0;
                m_id   = e1;
                m_data = e1 ? req1_data : req0_data;
                m_cnt  = ref_count(m_data);
                drop0  = e0;
                drop1  = e1;
            end
        end else begin
            m_ph++;
            chk("ready_busy", 32'({req0_ready, req1_ready}), 32'd0);
            if (m_ph == 1) chk("clear", 32'({det_clr, det_seq, res_valid}), 32'b100);
            else if (m_ph <= W + 1) chk("shift", 32'({det_clr, det_seq, res_valid}), 32'({1'b0, m_data[W+1-m_ph], 1'b0}));
            else begin
                chk("report", 32'({det_clr, det_seq, res_valid, res_id, res_count}), 32'({3'b001, m_id, m_cnt}));
                if (res_ready) begin
                    a_id.push_back(res_id);
                    a_cnt.push_back(res_count);
                    m_busy = 1'b0;
                    m_last = m_id;
                end
            end
        end
    endtask

    // sample at negedge, then release accepted requests just after the next rising edge
    task automatic cycle();
        drop0 = 1'b0;
        drop1 = 1'b0;
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        if (drop0) req0_valid = 1'b0;
        if (drop1) req1_valid = 1'b0;
    endtask

    initial begin
        tv[0] = '{1'b1, 1'b1, 8'hA8, 8'h15, 1'b1, 1'b0, 4'd2, 1'b1, 4'd2};
        tv[1] = '{1'b1, 1'b0, 8'h54, 8'h00, 1'b0, 1'b0, 4'd2, 1'b0, 4'd0};
        tv[2] = '{1'b0, 1'b1, 8'h00, 8'hAA, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0};
        tv[3] = '{1'b0, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0};
        tv[4] = '{1'b1, 1'b1, 8'h00, 8'h05, 1'b1, 1'b0, 4'd0, 1'b1, 4'd1};
        tv[5] = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 4'd1, 1'b0, 4'd0};
        tv[6] = '{1'b1, 1'b1, 8'hB5, 8'h5A, 1'b1, 1'b1, 4'd2, 1'b0, 4'd3};
        repeat (3) cycle();
        rst = 1'b1;
        for (int k = 0; k < 7; k++) begin
            a_id.delete();
            a_cnt.delete();
            if (tv[k].v0) begin req0_valid = 1'b1; req0_data = tv[k].d0; end
            if (tv[k].v1) begin req1_valid = 1'b1; req1_data = tv[k].d1; end
            t = 0;
            while (a_id.size() < (tv[k].two ? 2 : 1) && t < 100) begin cycle(); t++; end
            if (a_id.size() < (tv[k].two ? 2 : 1)) chk("vec_timeout", 32'(a_id.size()), 32'(tv[k].two ? 2 : 1));
            else begin
                chk("vec_id_a", 32'(a_id[0]), 32'(tv[k].id_a));
                chk("vec_cnt_a", 32'(a_cnt[0]), 32'(tv[k].cnt_a));
                if (tv[k].two) begin
                    chk("vec_id_b", 32'(a_id[1]), 32'(tv[k].id_b));
                    chk("vec_cnt_b", 32'(a_cnt[1]), 32'(tv[k].cnt_b));
                end
            end
            cycle();
        end
        // result held under back-pressure with another request pending
        res_ready  = 1'b0;
        req0_valid = 1'b1; req0_data = 8'h54;
        req1_valid = 1'b1; req1_data = 8'hAA;
        t = 0;
        while (!(m_busy && m_ph >= W + 2) && t < 50) begin cycle(); t++; end
        chk("bp_reach", 32'(m_busy && m_ph >= W + 2), 32'd1);
        repeat (20) cycle();
        res_ready = 1'b1;
        t = 0;
        while ((m_busy || req0_valid || req1_valid) && t < 100) begin cycle(); t++; end
        chk("bp_drain", 32'(m_busy || req0_valid || req1_valid), 32'd0);
        // reset during SHIFT cycle 4 aborts the frame
        req0_valid = 1'b1; req0_data = 8'hAA;
        t = 0;
        while (!(m_busy && m_ph == 5) && t < 50) begin cycle(); t++; end
        req1_valid = 1'b1; req1_data = 8'h55;
        rst = 1'b0;
        #1;
        chk("async_rst", 32'({req0_ready, req1_ready, det_clr, det_seq, res_valid, res_id, res_count, busy}), 32'd0);
        m_busy = 1'b0;
        m_last = 1'b1;
        repeat (3) cycle();
        req1_valid = 1'b0;
        rst = 1'b1;
        repeat (15) cycle();
        // random traffic with random back-pressure
        for (int c = 0; c < 1500; c++) begin
            res_ready = $urandom_range(0, 3) != 0;
            if (!req0_valid && $urandom_range(0, 2) == 0) begin req0_valid = 1'b1; req0_data = 8'($urandom); end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin req1_valid = 1'b1; req1_data = 8'($urandom); end
            cycle();
        end
        res_ready = 1'b1;
        t = 0;
        while ((m_busy || req0_valid || req1_valid) && t < 300) begin cycle(); t++; end
        chk("final_drain", 32'(m_busy || req0_valid || req1_valid), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
